palette_lut_db: RTL

PALETTE_LUT_DB -- requirements
Module: palette_lut_db

---
 rtl/palette_lut_db.sv | 65 ++++++
 1 files changed

// File: rtl/palette_lut_db.sv
// palette_lut_db: double-buffered RGB palette LUT with layered transparency compositing, 2-stage pixel path and Avalon-MM shadow-bank access
module palette_lut_db #(
  parameter int INDEX_W = 8,
  parameter int COLOR_W = 4,
  parameter int LAYERS = 2,
  parameter int TRANSP_INDEX = 0,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        pix_valid_in,
  input  logic [LAYERS*INDEX_W-1:0]   pix_index_in,
  input  logic                        pix_blank_in,
  input  logic                        frame_sync,
  output logic [COLOR_W-1:0]          red,
  output logic [COLOR_W-1:0]          green,
  output logic [COLOR_W-1:0]          blue,
  output logic                        pix_valid_out,
  input  logic [INDEX_W:0]            avl_address,
  input  logic                        avl_write,
  input  logic                        avl_read,
  input  logic [3*COLOR_W-1:0]        avl_writedata,
  output logic [3*COLOR_W-1:0]        avl_readdata
);
  localparam int CW = 3*COLOR_W;
  logic [CW-1:0] pal [2**(INDEX_W+1)];
  logic active_bank, swap_pending;
  logic [LAYERS*INDEX_W-1:0] s1_idx;
  logic s1_valid, s1_blank, s1_bank;
  logic [CW-1:0] color;
  logic sel_ctl, swap_set;
  logic [INDEX_W-1:0] addr;
  assign addr = avl_address[INDEX_W-1:0];
  assign sel_ctl = avl_address[INDEX_W];
  assign swap_set = avl_write & sel_ctl & avl_writedata[0];
  always_ff @(posedge clk)
    if (avl_write && !sel_ctl) pal[{~active_bank, addr}] <= avl_writedata;
  always_comb begin
    color = BG_COLOR;
    for (int k = 0; k < LAYERS; k++)
      if (s1_idx[k*INDEX_W +: INDEX_W] != INDEX_W'(TRANSP_INDEX)) color = pal[{s1_bank, s1_idx[k*INDEX_W +: INDEX_W]}];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      active_bank <= 1'b0;
      swap_pending <= 1'b0;
      s1_valid <= 1'b0;
      s1_blank <= 1'b0;
      s1_bank <= 1'b0;
      s1_idx <= '0;
      pix_valid_out <= 1'b0;
      {red, green, blue} <= '0;
      avl_readdata <= '0;
    end else begin
      if (frame_sync && swap_pending) active_bank <= ~active_bank;
      swap_pending <= swap_set | (swap_pending & ~frame_sync);
      if (avl_read) avl_readdata <= sel_ctl ? CW'({swap_pending, active_bank}) : pal[{~active_bank, addr}];
      s1_valid <= pix_valid_in;
      s1_blank <= pix_blank_in;
      s1_bank <= active_bank;
      s1_idx <= pix_index_in;
      pix_valid_out <= s1_valid;
      if (s1_valid) {red, green, blue} <= s1_blank ? '0 : color;
    end
endmodule
